// File: rtl/decode_stage.sv
// RV32I decode stage: turns the fetched instruction into register indices, immediate,
// one-hot opcode class / ALU op and exception flags, registered for execute.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clk_en_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_clk_en,
    input  logic            stall,
    input  logic            flush,
    output logic            stall_decode,
    output logic            clk_en,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [2:0]      funct3,
    output logic [31:0]     imm,
    output logic [10:0]     opcode,
    output logic [13:0]     alu_op,
    output logic [3:0]      exception
);
    localparam int OP_RTYPE = 10, OP_ITYPE = 9, OP_LOAD = 8, OP_STORE = 7, OP_BRANCH = 6;
    localparam int OP_JAL = 5, OP_JALR = 4, OP_LUI = 3, OP_AUIPC = 2, OP_SYSTEM = 1, OP_FENCE = 0;
    localparam int A_ADD = 13, A_SUB = 12, A_SLT = 11, A_SLTU = 10, A_XOR = 9, A_OR = 8, A_AND = 7;
    localparam int A_SLL = 6, A_SRL = 5, A_SRA = 4, A_EQ = 3, A_NEQ = 2, A_GE = 1, A_GEU = 0;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [10:0] cls;
    logic [10:0] opc_dec;
    logic [13:0] alu_dec;
    logic [31:0] imm_dec;
    logic        bad_fn, sys_priv, is_ecall, is_ebreak, is_mret, illegal;
    logic        uses_rs1, uses_rs2, stall_bit, load_en;

    logic            clk_en_q, clk_en_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d, imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [10:0]     opc_q, opc_d;
    logic [13:0]     alu_q, alu_d;
    logic [3:0]      exc_q, exc_d;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    always_comb begin
        cls = '0;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:2])
                5'b01100: cls[OP_RTYPE]  = 1'b1;
                5'b00100: cls[OP_ITYPE]  = 1'b1;
                5'b00000: cls[OP_LOAD]   = 1'b1;
                5'b01000: cls[OP_STORE]  = 1'b1;
                5'b11000: cls[OP_BRANCH] = 1'b1;
                5'b11011: cls[OP_JAL]    = 1'b1;
                5'b11001: cls[OP_JALR]   = 1'b1;
                5'b01101: cls[OP_LUI]    = 1'b1;
                5'b00101: cls[OP_AUIPC]  = 1'b1;
                5'b11100: cls[OP_SYSTEM] = 1'b1;
                5'b00011: cls[OP_FENCE]  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bad_fn = 1'b0;
        if (cls[OP_RTYPE])
            bad_fn = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
        if (cls[OP_ITYPE] && f3 == 3'b001)
            bad_fn = (f7 != 7'h00);
        if (cls[OP_ITYPE] && f3 == 3'b101)
            bad_fn = (f7 != 7'h00) && (f7 != 7'h20);
        if (cls[OP_LOAD])
            bad_fn = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        if (cls[OP_STORE])
            bad_fn = (f3 > 3'b010);
        if (cls[OP_BRANCH])
            bad_fn = (f3[2:1] == 2'b01);
        if (cls[OP_JALR])
            bad_fn = (f3 != 3'b000);
    end

    // funct3=000 system space only admits ecall/ebreak/mret; other funct3 are CSR ops
    assign sys_priv  = cls[OP_SYSTEM] && (f3 == 3'b000);
    assign is_ecall  = sys_priv && (instr_i[31:7] == 25'h0000000);
    assign is_ebreak = sys_priv && (instr_i[31:7] == 25'h0002000);
    assign is_mret   = sys_priv && (instr_i[31:7] == 25'h0604000);
    assign illegal   = (instr_i[1:0] != 2'b11) || (cls == '0) || bad_fn
                     || (sys_priv && !(is_ecall || is_ebreak || is_mret));

    always_comb begin
        imm_dec = '0;
        if (cls[OP_ITYPE] || cls[OP_LOAD] || cls[OP_JALR] || (cls[OP_SYSTEM] && f3 != 3'b000))
            imm_dec = {{20{instr_i[31]}}, instr_i[31:20]};
        else if (cls[OP_STORE])
            imm_dec = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        else if (cls[OP_BRANCH])
            imm_dec = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        else if (cls[OP_LUI] || cls[OP_AUIPC])
            imm_dec = {instr_i[31:12], 12'h000};
        else if (cls[OP_JAL])
            imm_dec = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    end

    always_comb begin
        alu_dec = '0;
        if (cls[OP_RTYPE] || cls[OP_ITYPE]) begin
            case (f3)
                3'b000: alu_dec[(cls[OP_RTYPE] && f7[5]) ? A_SUB : A_ADD] = 1'b1;
                3'b001: alu_dec[A_SLL]  = 1'b1;
                3'b010: alu_dec[A_SLT]  = 1'b1;
                3'b011: alu_dec[A_SLTU] = 1'b1;
                3'b100: alu_dec[A_XOR]  = 1'b1;
                3'b101: alu_dec[f7[5] ? A_SRA : A_SRL] = 1'b1;
                3'b110: alu_dec[A_OR]   = 1'b1;
                default: alu_dec[A_AND] = 1'b1;
            endcase
        end else if (cls[OP_BRANCH]) begin
            case (f3)
                3'b000: alu_dec[A_EQ]   = 1'b1;
                3'b001: alu_dec[A_NEQ]  = 1'b1;
                3'b100: alu_dec[A_SLT]  = 1'b1;
                3'b101: alu_dec[A_GE]   = 1'b1;
                3'b110: alu_dec[A_SLTU] = 1'b1;
                3'b111: alu_dec[A_GEU]  = 1'b1;
                default: ;
            endcase
        end else if (cls[OP_LOAD] || cls[OP_STORE] || cls[OP_JAL] || cls[OP_JALR]
                     || cls[OP_LUI] || cls[OP_AUIPC]) begin
            alu_dec[A_ADD] = 1'b1;
        end
    end

    assign opc_dec = illegal ? 11'd0 : cls;

    assign uses_rs1 = opc_dec[OP_RTYPE] | opc_dec[OP_ITYPE] | opc_dec[OP_LOAD]
                    | opc_dec[OP_STORE] | opc_dec[OP_BRANCH] | opc_dec[OP_JALR];
    assign uses_rs2 = opc_dec[OP_RTYPE] | opc_dec[OP_STORE] | opc_dec[OP_BRANCH];

    assign stall_decode = clk_en_i && ex_clk_en && ex_is_load && (ex_rd_addr != 5'd0)
                        && ((uses_rs1 && instr_i[19:15] == ex_rd_addr)
                            || (uses_rs2 && instr_i[24:20] == ex_rd_addr));
    assign stall_bit = stall | stall_decode;
    assign load_en   = clk_en_i & ~stall_bit;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        imm_d   = imm_q;
        opc_d   = opc_q;
        alu_d   = alu_q;
        exc_d   = exc_q;
        if (load_en) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            rs1_d   = instr_i[19:15];
            rs2_d   = instr_i[24:20];
            rd_d    = instr_i[11:7];
            f3_d    = f3;
            imm_d   = imm_dec;
            opc_d   = opc_dec;
            alu_d   = illegal ? 14'd0 : alu_dec;
            exc_d   = {illegal, is_ecall & ~illegal, is_ebreak & ~illegal, is_mret & ~illegal};
        end
    end

    // a global stall freezes the valid bit; a load-use stall alone inserts a bubble
    always_comb begin
        clk_en_d = clk_en_q;
        if (!stall_bit && flush)
            clk_en_d = 1'b0;
        else if (!stall_bit)
            clk_en_d = clk_en_i;
        else if (!stall)
            clk_en_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_en_q <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            imm_q    <= '0;
            opc_q    <= '0;
            alu_q    <= '0;
            exc_q    <= '0;
        end else begin
            clk_en_q <= clk_en_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            imm_q    <= imm_d;
            opc_q    <= opc_d;
            alu_q    <= alu_d;
            exc_q    <= exc_d;
        end
    end

    assign clk_en    = clk_en_q;
    assign pc_o      = pc_q;
    assign instr_o   = instr_q;
    assign rs1_addr  = rs1_q;
    assign rs2_addr  = rs2_q;
    assign rd_addr   = rd_q;
    assign funct3    = f3_q;
    assign imm       = imm_q;
    assign opcode    = opc_q;
    assign alu_op    = alu_q;
    assign exception = exc_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of hand-decoded instructions plus
// load-use, stall/flush and async-reset sequences.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rstn;
    logic        clk_en_i;
    logic [31:0] pc_i, instr_i;
    logic        ex_is_load, ex_clk_en, stall, flush;
    logic [4:0]  ex_rd_addr;
    logic        stall_decode, clk_en;
    logic [31:0] pc_o, instr_o, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  funct3;
    logic [10:0] opcode;
    logic [13:0] alu_op;
    logic [3:0]  exception;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [10:0] opc;
        logic [13:0] alu;
        logic [3:0]  exc;
    } vec_t;

    vec_t vecs[16];

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .clk_en_i(clk_en_i), .pc_i(pc_i), .instr_i(instr_i),
        .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_clk_en(ex_clk_en),
        .stall(stall), .flush(flush), .stall_decode(stall_decode), .clk_en(clk_en),
        .pc_o(pc_o), .instr_o(instr_o), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .funct3(funct3), .imm(imm), .opcode(opcode),
        .alu_op(alu_op), .exception(exception)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] immv,
                                input logic [10:0] opc, input logic [13:0] alu, input logic [3:0] exc);
        vec_t v;
        v.instr = instr; v.pc = 32'h0; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.f3 = f3;
        v.imm = immv; v.opc = opc; v.alu = alu; v.exc = exc;
        return v;
    endfunction

    function automatic logic [159:0] dut_outs();
        return {16'h0, clk_en, pc_o, instr_o, rs1_addr, rs2_addr, rd_addr, funct3, imm, opcode, alu_op, exception};
    endfunction

    function automatic logic [159:0] exp_of(input vec_t v, input logic ce);
        return {16'h0, ce, v.pc, v.instr, v.rs1, v.rs2, v.rd, v.f3, v.imm, v.opc, v.alu, v.exc};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        clk_en_i = 1'b1;
        instr_i  = v.instr;
        pc_i     = v.pc;
    endtask

    initial begin
        vec_t v, held;
        vecs[0]  = mk(32'hFFD08293, 5'd1, 5'd29, 5'd5,  3'd0, 32'hFFFFFFFD, 11'h200, 14'h2000, 4'h0); // addi x5,x1,-3
        vecs[1]  = mk(32'hFE311CE3, 5'd2, 5'd3,  5'd25, 3'd1, 32'hFFFFFFF8, 11'h040, 14'h0004, 4'h0); // bne x2,x3,-8
        vecs[2]  = mk(32'h00728333, 5'd5, 5'd7,  5'd6,  3'd0, 32'h00000000, 11'h400, 14'h2000, 4'h0); // add x6,x5,x7
        vecs[3]  = mk(32'h403100B3, 5'd2, 5'd3,  5'd1,  3'd0, 32'h00000000, 11'h400, 14'h1000, 4'h0); // sub x1,x2,x3
        vecs[4]  = mk(32'h4030D093, 5'd1, 5'd3,  5'd1,  3'd5, 32'h00000403, 11'h200, 14'h0010, 4'h0); // srai x1,x1,3
        vecs[5]  = mk(32'h0040A283, 5'd1, 5'd4,  5'd5,  3'd2, 32'h00000004, 11'h100, 14'h2000, 4'h0); // lw x5,4(x1)
        vecs[6]  = mk(32'h0050A423, 5'd1, 5'd5,  5'd8,  3'd2, 32'h00000008, 11'h080, 14'h2000, 4'h0); // sw x5,8(x1)
        vecs[7]  = mk(32'h123451B7, 5'd8, 5'd3,  5'd3,  3'd5, 32'h12345000, 11'h008, 14'h2000, 4'h0); // lui x3,0x12345
        vecs[8]  = mk(32'h010000EF, 5'd0, 5'd16, 5'd1,  3'd0, 32'h00000010, 11'h020, 14'h2000, 4'h0); // jal x1,+16
        vecs[9]  = mk(32'h00000073, 5'd0, 5'd0,  5'd0,  3'd0, 32'h00000000, 11'h002, 14'h0000, 4'h4); // ecall
        vecs[10] = mk(32'h00100073, 5'd0, 5'd1,  5'd0,  3'd0, 32'h00000000, 11'h002, 14'h0000, 4'h2); // ebreak
        vecs[11] = mk(32'h30200073, 5'd0, 5'd2,  5'd0,  3'd0, 32'h00000000, 11'h002, 14'h0000, 4'h1); // mret
        vecs[12] = mk(32'h00000000, 5'd0, 5'd0,  5'd0,  3'd0, 32'h00000000, 11'h000, 14'h0000, 4'h8); // compressed
        vecs[13] = mk(32'h00003003, 5'd0, 5'd0,  5'd0,  3'd3, 32'h00000000, 11'h000, 14'h0000, 4'h8); // load f3=011
        vecs[14] = mk(32'h02000033, 5'd0, 5'd0,  5'd0,  3'd0, 32'h00000000, 11'h000, 14'h0000, 4'h8); // mul (bad funct7)
        vecs[15] = mk(32'h00001067, 5'd0, 5'd0,  5'd1 - 5'd1, 3'd1, 32'h00000000, 11'h000, 14'h0000, 4'h8); // jalr f3=001
        for (int i = 0; i < 16; i++) vecs[i].pc = 32'h100 + 32'(4 * i);

        // clock/reset
        rstn = 1'b0; clk_en_i = 1'b0; pc_i = '0; instr_i = '0;
        ex_is_load = 1'b0; ex_rd_addr = '0; ex_clk_en = 1'b0; stall = 1'b0; flush = 1'b0;
        step(); step();
        check("reset_outputs", dut_outs(), 160'h0);
        rstn = 1'b1;
        check("reset_no_stall", {159'h0, stall_decode}, 160'h0);

        // table-driven decode
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("vec%0d_%h", i, vecs[i].instr), dut_outs(), exp_of(vecs[i], 1'b1));
        end

        // load-use on rs1: one stall cycle, one bubble, then the add
        v = vecs[0]; v.pc = 32'h300; held = v;
        drive(v); step();
        v = vecs[2]; v.pc = 32'h304;
        drive(v); ex_is_load = 1'b1; ex_clk_en = 1'b1; ex_rd_addr = 5'd5;
        #1 check("lu_stall_rs1", {159'h0, stall_decode}, {159'h0, 1'b1});
        step();
        check("lu_bubble", dut_outs(), exp_of(held, 1'b0));
        ex_clk_en = 1'b0;
        #1 check("lu_released", {159'h0, stall_decode}, 160'h0);
        step();
        check("lu_add_latched", dut_outs(), exp_of(v, 1'b1));
        ex_clk_en = 1'b1; ex_rd_addr = 5'd0;
        #1 check("lu_rd0_no_stall", {159'h0, stall_decode}, 160'h0);
        ex_rd_addr = 5'd7;
        #1 check("lu_stall_rs2", {159'h0, stall_decode}, {159'h0, 1'b1});
        v = vecs[0]; v.pc = 32'h308; drive(v); ex_rd_addr = 5'd29;
        #1 check("lu_itype_ignores_rs2", {159'h0, stall_decode}, 160'h0);
        step();
        check("lu_rd0_pass", dut_outs(), exp_of(v, 1'b1));
        ex_clk_en = 1'b0; ex_is_load = 1'b0; ex_rd_addr = 5'd0;

        // global stall for 3 cycles, flush raised mid-stall and held until accepted
        v = vecs[7]; v.pc = 32'h400; held = v;
        drive(v); step();
        v = vecs[3]; v.pc = 32'h404;
        drive(v); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) flush = 1'b1;
            step();
            check($sformatf("stall_hold_%0d", i), dut_outs(), exp_of(held, 1'b1));
        end
        stall = 1'b0;
        step();
        check("flush_after_stall", dut_outs(), exp_of(v, 1'b0));
        flush = 1'b0;
        v = vecs[4]; v.pc = 32'h408; drive(v); step();
        check("resume_after_flush", dut_outs(), exp_of(v, 1'b1));

        // flush and load-use in the same cycle: flush wins, fetch still held
        v = vecs[9]; v.pc = 32'h4F0; held = v;
        drive(v); step();
        v = vecs[2]; v.pc = 32'h500; drive(v);
        ex_is_load = 1'b1; ex_clk_en = 1'b1; ex_rd_addr = 5'd5; flush = 1'b1;
        #1 check("flush_lu_stall", {159'h0, stall_decode}, {159'h0, 1'b1});
        step();
        check("flush_lu_outputs", dut_outs(), exp_of(held, 1'b0));
        flush = 1'b0; ex_clk_en = 1'b0;

        // async reset in the middle of a load-use stall
        v = vecs[0]; v.pc = 32'h600; drive(v); step();
        v = vecs[2]; v.pc = 32'h604; drive(v); ex_clk_en = 1'b1;
        step();
        #2 rstn = 1'b0;
        #1 check("async_reset", dut_outs(), 160'h0);
        step();
        rstn = 1'b1; ex_clk_en = 1'b0; ex_is_load = 1'b0; ex_rd_addr = 5'd0;
        v = vecs[0]; v.pc = 32'h700; drive(v);
        #1 check("post_reset_idle", dut_outs(), 160'h0);
        step();
        check("post_reset_first", dut_outs(), exp_of(v, 1'b1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
